div_unit: RTL and testbench

//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU. Sits beside alu in the

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 190 +++++++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Operand/result bundle between the execute stage and the iterative divider.
interface div_unit_if #(
  parameter int MP_DATA_WIDTH = 32
);
  logic                     iflush;
  logic                     ivalid;
  logic [1:0]               iop;
  logic [MP_DATA_WIDTH-1:0] isrc_a;
  logic [MP_DATA_WIDTH-1:0] isrc_b;
  logic                     oready;
  logic                     obusy;
  logic                     ovalid;
  logic [MP_DATA_WIDTH-1:0] oresult;

  modport master (
    output iflush, ivalid, iop, isrc_a, isrc_b,
    input  oready, obusy, ovalid, oresult
  );

  modport slave (
    input  iflush, ivalid, iop, isrc_a, isrc_b,
    output oready, obusy, ovalid, oresult
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, W steps per operation.
// Define DIV_FAST_ZERO_EN to retire divide-by-zero and signed overflow straight from IDLE.
module div_unit #(
  parameter int MP_DATA_WIDTH = 32
) (
  input logic       iclk,
  input logic       irst,
  div_unit_if.slave bus
);
  localparam int W  = MP_DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ONE_VAL  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [1:0]    op_r;
  logic [W-1:0]  quo_r, rem_r, div_r, a_orig_r, result_r, result_nxt_s;
  logic          bz_r, ovf_r, q_neg_r, r_neg_r;
  logic          ready_r, busy_r, valid_r;
  logic          ready_nxt_s, busy_nxt_s, valid_nxt_s;
  logic          in_signed_s, in_bz_s, in_ovf_s, accept_s, fast_s;
  logic [W:0]    rem_shift_s;
  logic [W-1:0]  diff_s, quo_step_s, rem_step_s;
  logic          ge_s;

  function automatic logic [W-1:0] negate(input logic [W-1:0] v);
    return ~v + ONE_VAL;
  endfunction

  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
    return v[W-1] ? negate(v) : v;
  endfunction

  // Special cases override the iterated values before any sign fix-up.
  function automatic logic [W-1:0] fmt_result(
    input logic [1:0] op, input logic [W-1:0] quo, input logic [W-1:0] rem,
    input logic [W-1:0] a_orig, input logic bz, input logic ovf,
    input logic qn, input logic rn);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (bz) begin
      q = {W{1'b1}};
      r = a_orig;
    end else if (ovf) begin
      q = MIN_VAL;
      r = {W{1'b0}};
    end else begin
      q = qn ? negate(quo) : quo;
      r = rn ? negate(rem) : rem;
    end
    return op[1] ? r : q;
  endfunction

  assign in_signed_s = ~bus.iop[0];
  assign in_bz_s     = (bus.isrc_b == {W{1'b0}});
  assign in_ovf_s    = in_signed_s & (bus.isrc_a == MIN_VAL) & (bus.isrc_b == {W{1'b1}});
  assign accept_s    = (state_r == ST_IDLE) & bus.ivalid & ~bus.iflush;

`ifdef DIV_FAST_ZERO_EN
  assign fast_s = in_bz_s | in_ovf_s;
`else
  assign fast_s = 1'b0;
`endif

  // The bit shifted out of rem is kept so divisors >= 2^(W-1) compare correctly.
  assign rem_shift_s = {rem_r, quo_r[W-1]};
  assign ge_s        = (rem_shift_s >= {1'b0, div_r});
  assign diff_s      = rem_shift_s[W-1:0] - div_r;
  assign quo_step_s  = {quo_r[W-2:0], ge_s};
  assign rem_step_s  = ge_s ? diff_s : rem_shift_s[W-1:0];

  // Result to capture on entry to DONE: from inputs on the fast path, else from the last step.
  always_comb begin
    if (state_r == ST_IDLE) begin
      result_nxt_s = fmt_result(bus.iop, {W{1'b0}}, {W{1'b0}}, bus.isrc_a,
                                in_bz_s, in_ovf_s, 1'b0, 1'b0);
    end else begin
      result_nxt_s = fmt_result(op_r, quo_step_s, rem_step_s, a_orig_r,
                                bz_r, ovf_r, q_neg_r, r_neg_r);
    end
  end

  // FSM state register.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; flush wins over everything.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = fast_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
    if (bus.iflush) begin
      state_nxt_s = ST_IDLE;
    end
  end

  // FSM outputs for the coming cycle, registered below.
  always_comb begin
    ready_nxt_s = (state_nxt_s == ST_IDLE);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    valid_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Output registers; oresult only changes when a new result is strobed.
  always_ff @(posedge iclk) begin
    if (irst) begin
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= {W{1'b0}};
    end else begin
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
      valid_r <= valid_nxt_s;
      if (state_nxt_s == ST_DONE) begin
        result_r <= result_nxt_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  // Operand capture on accept, one restoring step per CALC cycle.
  always_ff @(posedge iclk) begin
    if (irst) begin
      cnt_r    <= {CW{1'b0}};
      op_r     <= 2'b00;
      quo_r    <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      div_r    <= {W{1'b0}};
      a_orig_r <= {W{1'b0}};
      bz_r     <= 1'b0;
      ovf_r    <= 1'b0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r    <= {CW{1'b0}};
      op_r     <= bus.iop;
      quo_r    <= in_signed_s ? abs_val(bus.isrc_a) : bus.isrc_a;
      rem_r    <= {W{1'b0}};
      div_r    <= in_signed_s ? abs_val(bus.isrc_b) : bus.isrc_b;
      a_orig_r <= bus.isrc_a;
      bz_r     <= in_bz_s;
      ovf_r    <= in_ovf_s;
      q_neg_r  <= in_signed_s & (bus.isrc_a[W-1] ^ bus.isrc_b[W-1]);
      r_neg_r  <= in_signed_s & bus.isrc_a[W-1];
    end else if (state_r == ST_CALC) begin
      cnt_r <= cnt_r + CNT_ONE;
      quo_r <= quo_step_s;
      rem_r <= rem_step_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.oready  = ready_r;
  assign bus.obusy   = busy_r;
  assign bus.ovalid  = valid_r;
  assign bus.oresult = result_r;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases, random ops, flush and reset.
module tb_div_unit;
  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_unit_if #(.MP_DATA_WIDTH(W)) bus ();
  div_unit #(.MP_DATA_WIDTH(W)) dut (.iclk(clk), .irst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int expected_cycles(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int c;
    c = W + 2;
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) c = 2;
`endif
    return c;
  endfunction

  // Issue one op and check busy/ready while waiting, result, latency and the single strobe.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noisy, input string tag);
    logic [31:0] exp;
    int exp_cyc;
    int ticks;
    bit seen;
    exp = model(op, a, b);
    exp_cyc = expected_cycles(op, a, b);
    bus.ivalid = 1'b1;
    bus.iop    = op;
    bus.isrc_a = a;
    bus.isrc_b = b;
    tick();
    ticks = 1;
    bus.ivalid = noisy;
    bus.iop    = 2'($urandom);
    bus.isrc_a = $urandom;
    bus.isrc_b = $urandom;
    seen = 1'b0;
    while (!seen && ticks < W + 10) begin
      if (bus.ovalid === 1'b1) begin
        seen = 1'b1;
      end else begin
        n_checks++;
        if (bus.obusy !== 1'b1 || bus.oready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy: obusy=%b oready=%b, expected 1/0", tag, bus.obusy, bus.oready);
        end
        tick();
        ticks++;
      end
    end
    bus.ivalid = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no ovalid after %0d cycles, expected at %0d", tag, ticks + 1, exp_cyc);
    end else begin
      if (bus.oresult !== exp || ticks + 1 != exp_cyc || bus.obusy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s op=%0d a=%h b=%h: result %h lat %0d busy %b, expected %h lat %0d busy 1",
                 tag, op, a, b, bus.oresult, ticks + 1, bus.obusy, exp, exp_cyc);
      end
      tick();
      n_checks++;
      if (bus.ovalid !== 1'b0 || bus.oready !== 1'b1 || bus.oresult !== exp) begin
        n_fail++;
        $display("FAIL %s after strobe: ovalid=%b oready=%b oresult=%h, expected 0/1/%h",
                 tag, bus.ovalid, bus.oready, bus.oresult, exp);
      end
    end
  endtask

  task automatic expect_idle_outputs(input logic [31:0] exp_res, input string tag);
    n_checks++;
    if (bus.oready !== 1'b1 || bus.obusy !== 1'b0 || bus.ovalid !== 1'b0 || bus.oresult !== exp_res) begin
      n_fail++;
      $display("FAIL %s: ready=%b busy=%b valid=%b result=%h, expected 1/0/0/%h",
               tag, bus.oready, bus.obusy, bus.ovalid, bus.oresult, exp_res);
    end
  endtask

  task automatic expect_no_strobe(input int cycles, input string tag);
    int strobes;
    strobes = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.ovalid === 1'b1) strobes++;
    end
    n_checks++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL %s: saw %0d ovalid strobes, expected 0", tag, strobes);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iflush = 1'b0;
    bus.ivalid = 1'b0;
    bus.iop    = 2'b00;
    bus.isrc_a = 32'd0;
    bus.isrc_b = 32'd0;
    tick();
    tick();
    expect_idle_outputs(32'd0, "reset");
    rst = 1'b0;
    tick();
    expect_idle_outputs(32'd0, "reset_release");
  endtask

  task automatic test_directed();
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "divu_100_7");
    run_op(OP_REM,  32'hFFFF_FF9C, 32'd7, 1'b0, "rem_neg100_7");
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7, 1'b0, "div_neg100_7");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_overflow");
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, 1'b0, "divu_by_zero");
    run_op(OP_REMU, 32'h0000_1234, 32'd0, 1'b0, "remu_by_zero");
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd0, 1'b0, "div_neg_by_zero");
    run_op(OP_REM,  32'hFFFF_FF9C, 32'd0, 1'b0, "rem_neg_by_zero");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "divu_big_divisor");
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "remu_big_divisor");
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divu_min_allones");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 48; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0;
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: b = b | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 255));
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_flush();
    bus.ivalid = 1'b1;
    bus.iop    = OP_DIVU;
    bus.isrc_a = 32'd1000;
    bus.isrc_b = 32'd3;
    tick();
    bus.ivalid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.iflush = 1'b1;
    tick();
    bus.iflush = 1'b0;
    n_checks++;
    if (bus.oready !== 1'b1 || bus.obusy !== 1'b0 || bus.ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mid_calc: ready=%b busy=%b valid=%b, expected 1/0/0",
               bus.oready, bus.obusy, bus.ovalid);
    end
    expect_no_strobe(W + 4, "flush_mid_calc_strobe");
    run_op(OP_DIVU, 32'd9, 32'd3, 1'b0, "divu_9_3_after_flush");

    bus.ivalid = 1'b1;
    bus.iflush = 1'b1;
    bus.iop    = OP_DIVU;
    bus.isrc_a = 32'd50;
    bus.isrc_b = 32'd5;
    tick();
    bus.ivalid = 1'b0;
    bus.iflush = 1'b0;
    n_checks++;
    if (bus.oready !== 1'b1 || bus.obusy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_same_cycle: ready=%b busy=%b, expected 1/0", bus.oready, bus.obusy);
    end
    expect_no_strobe(W + 4, "flush_same_cycle_strobe");
  endtask

  task automatic test_reset_mid();
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, "pre_reset_op");
    bus.ivalid = 1'b1;
    bus.iop    = OP_REMU;
    bus.isrc_a = 32'd77;
    bus.isrc_b = 32'd5;
    tick();
    bus.ivalid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    expect_idle_outputs(32'd0, "reset_mid_calc");
    rst = 1'b0;
    expect_no_strobe(W + 4, "reset_mid_calc_strobe");
    run_op(OP_REM, 32'd77, 32'hFFFF_FFFB, 1'b0, "rem_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(OP_DIV,  32'd12345, 32'hFFFF_FFF9, 1'b1, "b2b_0");
    run_op(OP_REMU, 32'd12345, 32'd100, 1'b1, "b2b_1");
    run_op(OP_DIVU, 32'd7, 32'd0, 1'b1, "b2b_2");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
